// File: rtl/msg_event_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : msg_event_queue_if
// Brief    : Event-in / entry-out bundle for the simulation message queue.
// Revision : 1.0
// ============================================================================
interface msg_event_queue_if #(
    parameter int DEPTH  = 16,
    parameter int SRC_W  = 8,
    parameter int CODE_W = 16,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
);
    logic                       evt_valid;
    logic [1:0]                 evt_type;
    logic [1:0]                 evt_svrt;
    logic [1:0]                 evt_act;
    logic [SRC_W-1:0]           evt_src;
    logic [CODE_W-1:0]          evt_code;

    logic                       m_valid;
    logic                       m_ready;
    logic [TS_W-1:0]            m_ts;
    logic [1:0]                 m_type;
    logic [1:0]                 m_svrt;
    logic [1:0]                 m_act;
    logic [SRC_W-1:0]           m_src;
    logic [CODE_W-1:0]          m_code;

    logic [$clog2(DEPTH):0]     level;
    logic                       ovf;
    logic [CNT_W-1:0]           drop_cnt;
    logic [CNT_W-1:0]           warn_cnt;
    logic [CNT_W-1:0]           err_cnt;
    logic [CNT_W-1:0]           fatal_cnt;
    logic                       stop_req;
    logic                       exit_req;

    // The queue itself sits on the slave side; producers/consumers use master.
    modport slave (
        input  evt_valid, evt_type, evt_svrt, evt_act, evt_src, evt_code, m_ready,
        output m_valid, m_ts, m_type, m_svrt, m_act, m_src, m_code,
        output level, ovf, drop_cnt, warn_cnt, err_cnt, fatal_cnt, stop_req, exit_req
    );

    modport master (
        output evt_valid, evt_type, evt_svrt, evt_act, evt_src, evt_code, m_ready,
        input  m_valid, m_ts, m_type, m_svrt, m_act, m_src, m_code,
        input  level, ovf, drop_cnt, warn_cnt, err_cnt, fatal_cnt, stop_req, exit_req
    );
endinterface
`default_nettype wire

// File: rtl/msg_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : msg_event_queue
// Brief    : Timestamping event FIFO with show-ahead output, statistics and
//            STOP/EXIT request pulses on consumption of flagged entries.
// Revision : 1.0
// ============================================================================
module msg_event_queue #(
    parameter int DEPTH  = 16,
    parameter int SRC_W  = 8,
    parameter int CODE_W = 16,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    msg_event_queue_if.slave    bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_EW = TS_W + 6 + SRC_W + CODE_W;

    localparam logic [1:0] c_TYPE_WARN  = 2'd1;
    localparam logic [1:0] c_TYPE_ERROR = 2'd2;
    localparam logic [1:0] c_TYPE_FATAL = 2'd3;
    localparam logic [1:0] c_ACT_STOP   = 2'd1;
    localparam logic [1:0] c_ACT_EXIT   = 2'd2;

    logic [TS_W-1:0]    ts_q;
    logic [c_PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   warn_q, warn_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   fatal_q, fatal_d;
    logic               stop_q, stop_d;
    logic               exit_q, exit_d;
    logic [c_EW-1:0]    mem_q [DEPTH];

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_EW-1:0]    w_wdata;
    logic [c_EW-1:0]    w_head;
    logic [1:0]         w_head_act;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]) &&
                     (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]);
    assign w_pop   = !w_empty && bus.m_ready;
    assign w_push  = bus.evt_valid && (!w_full || w_pop);
    assign w_drop  = bus.evt_valid && w_full && !w_pop;

    assign w_wdata = {ts_q, bus.evt_type, bus.evt_svrt, bus.evt_act, bus.evt_src, bus.evt_code};

    // Fields read as zero while empty so stale storage never leaks out.
    assign w_head     = w_empty ? '0 : mem_q[rd_ptr_q[c_AW-1:0]];
    assign w_head_act = w_head[CODE_W+SRC_W +: 2];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        ovf_d   = ovf_q | w_drop;
        drop_d  = sat_inc(drop_q,  w_drop);
        warn_d  = sat_inc(warn_q,  bus.evt_valid && (bus.evt_type == c_TYPE_WARN));
        err_d   = sat_inc(err_q,   bus.evt_valid && (bus.evt_type == c_TYPE_ERROR));
        fatal_d = sat_inc(fatal_q, bus.evt_valid && (bus.evt_type == c_TYPE_FATAL));
        stop_d  = w_pop && (w_head_act == c_ACT_STOP);
        exit_d  = w_pop && (w_head_act == c_ACT_EXIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            warn_q   <= '0;
            err_q    <= '0;
            fatal_q  <= '0;
            stop_q   <= 1'b0;
            exit_q   <= 1'b0;
        end else begin
            ts_q     <= ts_q + 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            warn_q   <= warn_d;
            err_q    <= err_d;
            fatal_q  <= fatal_d;
            stop_q   <= stop_d;
            exit_q   <= exit_d;
        end
    end

    // Storage needs no reset: visibility is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= w_wdata;
        end
    end

    assign bus.m_valid   = !w_empty;
    assign bus.m_code    = w_head[0 +: CODE_W];
    assign bus.m_src     = w_head[CODE_W +: SRC_W];
    assign bus.m_act     = w_head_act;
    assign bus.m_svrt    = w_head[CODE_W+SRC_W+2 +: 2];
    assign bus.m_type    = w_head[CODE_W+SRC_W+4 +: 2];
    assign bus.m_ts      = w_head[c_EW-1 -: TS_W];
    assign bus.level     = wr_ptr_q - rd_ptr_q;
    assign bus.ovf       = ovf_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.warn_cnt  = warn_q;
    assign bus.err_cnt   = err_q;
    assign bus.fatal_cnt = fatal_q;
    assign bus.stop_req  = stop_q;
    assign bus.exit_req  = exit_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_event_queue
// Brief    : Self-checking bench for msg_event_queue against a queue-based model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_msg_event_queue;
    localparam int DEPTH  = 16;
    localparam int SRC_W  = 8;
    localparam int CODE_W = 16;
    localparam int TS_W   = 32;
    localparam int CNT_W  = 16;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msg_event_queue_if #(.DEPTH(DEPTH), .SRC_W(SRC_W), .CODE_W(CODE_W),
                         .TS_W(TS_W), .CNT_W(CNT_W)) bus ();

    msg_event_queue #(.DEPTH(DEPTH), .SRC_W(SRC_W), .CODE_W(CODE_W),
                      .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [TS_W-1:0]   ts;
        logic [1:0]        ty;
        logic [1:0]        sv;
        logic [1:0]        act;
        logic [SRC_W-1:0]  src;
        logic [CODE_W-1:0] code;
    } ent_t;

    ent_t            q[$];
    logic [TS_W-1:0] md_ts;
    int              md_drop, md_warn, md_err, md_fatal;
    bit              md_ovf, md_stop, md_exit;

    function automatic int sat(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        bit   pop;
        bit   push;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            md_ts = '0; md_drop = 0; md_warn = 0; md_err = 0; md_fatal = 0;
            md_ovf = 0; md_stop = 0; md_exit = 0;
        end else begin
            pop  = bus.m_ready && (q.size() > 0);
            push = 1'b0;
            md_stop = pop && (q[0].act == 2'd1);
            md_exit = pop && (q[0].act == 2'd2);
            if (bus.evt_valid) begin
                if (bus.evt_type == 2'd1) md_warn  = sat(md_warn);
                if (bus.evt_type == 2'd2) md_err   = sat(md_err);
                if (bus.evt_type == 2'd3) md_fatal = sat(md_fatal);
                if (q.size() < DEPTH || pop) begin
                    e.ts = md_ts; e.ty = bus.evt_type; e.sv = bus.evt_svrt;
                    e.act = bus.evt_act; e.src = bus.evt_src; e.code = bus.evt_code;
                    push = 1'b1;
                end else begin
                    md_ovf  = 1'b1;
                    md_drop = sat(md_drop);
                end
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
            md_ts = md_ts + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit   v;
            ent_t h;
            v = (q.size() > 0);
            if (v) h = q[0];
            else begin
                h.ts = '0; h.ty = '0; h.sv = '0; h.act = '0; h.src = '0; h.code = '0;
            end
            chk("m_valid",   bus.m_valid,   v);
            chk("m_ts",      bus.m_ts,      h.ts);
            chk("m_type",    bus.m_type,    h.ty);
            chk("m_svrt",    bus.m_svrt,    h.sv);
            chk("m_act",     bus.m_act,     h.act);
            chk("m_src",     bus.m_src,     h.src);
            chk("m_code",    bus.m_code,    h.code);
            chk("level",     bus.level,     q.size());
            chk("ovf",       bus.ovf,       md_ovf);
            chk("drop_cnt",  bus.drop_cnt,  md_drop);
            chk("warn_cnt",  bus.warn_cnt,  md_warn);
            chk("err_cnt",   bus.err_cnt,   md_err);
            chk("fatal_cnt", bus.fatal_cnt, md_fatal);
            chk("stop_req",  bus.stop_req,  md_stop);
            chk("exit_req",  bus.exit_req,  md_exit);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic evt(input logic v, input logic [1:0] ty, input logic [1:0] sv,
                       input logic [1:0] act, input logic [SRC_W-1:0] src,
                       input logic [CODE_W-1:0] code);
        bus.evt_valid = v;
        bus.evt_type  = ty;
        bus.evt_svrt  = sv;
        bus.evt_act   = act;
        bus.evt_src   = src;
        bus.evt_code  = code;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        bus.m_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;

        // Idle: ts counts 0..4, now in the ts=5 cycle.
        repeat (5) tick();
        chk("idle_m_valid", bus.m_valid, 0);
        chk("idle_level",   bus.level,   0);
        chk("idle_warn",    bus.warn_cnt, 0);
        chk("idle_drop",    bus.drop_cnt, 0);
        evt(1'b1, 2'd0, 2'd0, 2'd0, 8'h01, 16'h0005);
        tick();
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        chk("ts5_valid", bus.m_valid, 1);
        chk("ts5_m_ts",  bus.m_ts,    5);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("ts7_level", bus.level, 0);
        evt(1'b1, 2'd1, 2'd2, 2'd0, 8'h12, 16'hBEEF);
        tick();
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        chk("warn_valid", bus.m_valid, 1);
        chk("warn_m_ts",  bus.m_ts,    7);
        chk("warn_type",  bus.m_type,  1);
        chk("warn_svrt",  bus.m_svrt,  2);
        chk("warn_act",   bus.m_act,   0);
        chk("warn_src",   bus.m_src,   8'h12);
        chk("warn_code",  bus.m_code,  16'hBEEF);
        chk("warn_cnt1",  bus.warn_cnt, 1);
        repeat (2) tick();
        chk("hold_m_ts",  bus.m_ts,   7);
        chk("hold_code",  bus.m_code, 16'hBEEF);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;

        // Overflow: 18 events into an empty 16-entry FIFO.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            evt(1'b1, 2'd0, 2'd1, 2'd0, 8'(i), 16'(i));
            tick();
        end
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        chk("ovf_level", bus.level,    16);
        chk("ovf_flag",  bus.ovf,      1);
        chk("ovf_drop",  bus.drop_cnt, 2);
        chk("ovf_head",  bus.m_code,   0);
        // Full with simultaneous push and pop: no drop.
        evt(1'b1, 2'd0, 2'd0, 2'd0, 8'hAA, 16'hAAAA);
        bus.m_ready = 1'b1;
        tick();
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        bus.m_ready = 1'b0;
        chk("fullpp_level", bus.level,    16);
        chk("fullpp_drop",  bus.drop_cnt, 2);
        chk("fullpp_head",  bus.m_code,   1);
        bus.m_ready = 1'b1;
        repeat (15) tick();
        chk("tail_code", bus.m_code, 16'hAAAA);
        tick();
        bus.m_ready = 1'b0;
        chk("drain_level", bus.level, 0);

        // Actions LOG, STOP, EXIT popped back-to-back.
        evt(1'b1, 2'd0, 2'd0, 2'd0, 8'h01, 16'h0001); tick();
        evt(1'b1, 2'd0, 2'd0, 2'd1, 8'h02, 16'h0002); tick();
        evt(1'b1, 2'd0, 2'd0, 2'd2, 8'h03, 16'h0003); tick();
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        bus.m_ready = 1'b1;
        tick();
        chk("act_log_stop", bus.stop_req, 0);
        chk("act_log_exit", bus.exit_req, 0);
        tick();
        chk("act_stop_stop", bus.stop_req, 1);
        chk("act_stop_exit", bus.exit_req, 0);
        tick();
        chk("act_exit_stop", bus.stop_req, 0);
        chk("act_exit_exit", bus.exit_req, 1);
        tick();
        chk("act_end_stop", bus.stop_req, 0);
        chk("act_end_exit", bus.exit_req, 0);
        bus.m_ready = 1'b0;

        // Randomized traffic: low drain rate first, then high.
        for (int i = 0; i < 1500; i++) begin
            evt(1'($urandom_range(0, 99) < 55), 2'($urandom), 2'($urandom), 2'($urandom),
                8'($urandom), 16'($urandom));
            bus.m_ready = ($urandom_range(0, 99) < ((i < 500) ? 30 : 70));
            tick();
        end
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        bus.m_ready = 1'b0;

        // Counter saturation, then reset mid-burst while a STOP entry pops.
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            evt(1'b1, 2'd2, 2'd3, 2'd0, 8'h55, 16'(i));
            tick();
        end
        chk("err_sat", bus.err_cnt, SAT);
        evt(1'b1, 2'd2, 2'd3, 2'd1, 8'h66, 16'h1234);
        repeat (3) tick();
        chk("burst_stop", bus.stop_req, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_m_valid", bus.m_valid,  0);
        chk("rst_level",   bus.level,    0);
        chk("rst_err",     bus.err_cnt,  0);
        chk("rst_ovf",     bus.ovf,      0);
        chk("rst_stop",    bus.stop_req, 0);
        chk("rst_exit",    bus.exit_req, 0);
        chk("rst_m_ts",    bus.m_ts,     0);
        chk("rst_m_code",  bus.m_code,   0);
        evt(1'b0, 2'd0, 2'd0, 2'd0, '0, '0);
        bus.m_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
